// File: rtl/aes32dsi_seq.sv
// aes32dsi_seq: multi-cycle AES decrypt-round helper (aes32dsi / aes32dsmi).
// Selects one byte of rs2, passes it through the inverse S-box, optionally
// through the inverse MixColumn multipliers, rotates it back into the byte
// position and XORs it into rs1.
// Optional feature: define AES32DSMI_EN to compile in the MIX state and the
// inverse-MixColumn multipliers; without it dsmi is ignored.
module aes32dsi_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [1:0]  bs,
  input  logic        dsmi,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        busy
);

`ifdef AES32DSMI_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    MIX  = 2'd2,
    DONE = 2'd3
  } stateT;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd3
  } stateT;
`endif

  stateT       r_state;
  stateT       w_nextState;
  logic [31:0] r_rs1;
  logic [1:0]  r_bs;
  logic [7:0]  r_byte;
  logic [31:0] r_word;
  logic [7:0]  w_selByte;
  logic [7:0]  w_invByte;
  logic [31:0] w_rotWord;

`ifdef AES32DSMI_EN
  logic        r_dsmi;
  logic [31:0] w_mixWord;
`else
  logic        w_unusedDsmi;
  assign w_unusedDsmi = dsmi;
`endif

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1 (shift-and-add)
  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0
  function automatic logic [7:0] gfInv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gfMul(sq, sq);
      acc = gfMul(acc, sq);
    end
    return acc;
  endfunction

  // Inverse S-box: undo the affine transform, then take the field inverse
  function automatic logic [7:0] invSbox(input logic [7:0] y);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) begin
      b[i] = y[(i + 2) % 8] ^ y[(i + 5) % 8] ^ y[(i + 7) % 8];
    end
    b = b ^ 8'h05;
    return gfInv(b);
  endfunction

  assign w_selByte = rs2[8*bs +: 8];
  assign w_invByte = invSbox(r_byte);

`ifdef AES32DSMI_EN
  assign w_mixWord = {gfMul(r_word[7:0], 8'h0B), gfMul(r_word[7:0], 8'h0D),
                      gfMul(r_word[7:0], 8'h09), gfMul(r_word[7:0], 8'h0E)};
`endif

  // Rotate the transformed word back into the selected byte lane
  always_comb begin
    w_rotWord = r_word;
    case (r_bs)
      2'd0:    w_rotWord = r_word;
      2'd1:    w_rotWord = {r_word[23:0], r_word[31:24]};
      2'd2:    w_rotWord = {r_word[15:0], r_word[31:16]};
      default: w_rotWord = {r_word[7:0],  r_word[31:8]};
    endcase
  end

  assign result = out_valid ? (r_rs1 ^ w_rotWord) : 32'h0;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  // Next-state and handshake outputs
  always_comb begin
    w_nextState = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) w_nextState = SUB;
      end
`ifdef AES32DSMI_EN
      SUB:  w_nextState = r_dsmi ? MIX : DONE;
      MIX:  w_nextState = DONE;
`else
      SUB:  w_nextState = DONE;
`endif
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Operand capture on accept, then S-box and MixColumn results as the FSM advances
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rs1  <= 32'h0;
      r_bs   <= 2'd0;
      r_byte <= 8'h0;
      r_word <= 32'h0;
`ifdef AES32DSMI_EN
      r_dsmi <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_rs1  <= rs1;
            r_bs   <= bs;
            r_byte <= w_selByte;
`ifdef AES32DSMI_EN
            r_dsmi <= dsmi;
`endif
          end
        end
        SUB:  r_word <= {24'h0, w_invByte};
`ifdef AES32DSMI_EN
        MIX:  r_word <= w_mixWord;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes32dsi_seq.sv
// tb_aes32dsi_seq: randomized self-checking bench for aes32dsi_seq.
// The reference builds the inverse S-box from first principles (brute-force
// field inverse plus the forward affine map, then inverted by table) and
// tracks the request in flight as "busy / cycles to result / expected word".
module tb_aes32dsi_seq;

`ifdef AES32DSMI_EN
  localparam bit DSMI_EN = 1'b1;
`else
  localparam bit DSMI_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        inValid;
  logic        inReady;
  logic [31:0] inRs1;
  logic [31:0] inRs2;
  logic [1:0]  inBs;
  logic        inDsmi;
  logic        outValid;
  logic        outReady;
  logic [31:0] result;
  logic        busy;

  int nChecks;
  int nErrors;

  logic [7:0] invS [256];

  bit          mInit;
  bit          mBusy;
  int          mWait;
  logic [31:0] mRes;

  aes32dsi_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .rs1       (inRs1),
    .rs2       (inRs2),
    .bs        (inBs),
    .dsmi      (inDsmi),
    .out_valid (outValid),
    .out_ready (outReady),
    .result    (result),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Carry-less product then polynomial long division by 0x11B
  function automatic logic [7:0] refMul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [31:0] rotl32(input logic [31:0] v, input int n);
    if (n == 0) return v;
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [31:0] refResult(input logic [31:0] r1, input logic [31:0] r2,
                                            input logic [1:0] b, input logic d);
    logic [7:0]  sel;
    logic [7:0]  x;
    logic [31:0] word;
    sel = 8'((r2 >> (8 * int'(b))) & 32'hFF);
    x   = invS[sel];
    if (d && DSMI_EN)
      word = {refMul(x, 8'h0B), refMul(x, 8'h0D), refMul(x, 8'h09), refMul(x, 8'h0E)};
    else
      word = {24'h0, x};
    return r1 ^ rotl32(word, 8 * int'(b));
  endfunction

  task automatic buildTables();
    logic [7:0] inv;
    logic [7:0] s;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      if (a != 0)
        for (int b = 1; b < 256; b++)
          if (refMul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      invS[s] = 8'(a);
    end
  endtask

  // Reference request tracker, advanced on every rising edge
  always @(posedge clk) begin
    if (rst) begin
      mInit <= 1'b1;
      mBusy <= 1'b0;
      mWait <= 0;
      mRes  <= 32'h0;
    end else if (mInit) begin
      if (!mBusy) begin
        if (inValid) begin
          mBusy <= 1'b1;
          mWait <= (inDsmi && DSMI_EN) ? 2 : 1;
          mRes  <= refResult(inRs1, inRs2, inBs, inDsmi);
        end
      end else if (mWait > 0) begin
        mWait <= mWait - 1;
      end else if (outReady) begin
        mBusy <= 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compareAll();
    logic expValid;
    if (!mInit) return;
    expValid = mBusy && (mWait == 0);
    checkOutput("cyc_in_ready",  32'(inReady),  32'(!mBusy));
    checkOutput("cyc_busy",      32'(busy),     32'(mBusy));
    checkOutput("cyc_out_valid", 32'(outValid), 32'(expValid));
    checkOutput("cyc_result",    result,        expValid ? mRes : 32'h0);
  endtask

  // One clock: compare on the falling edge, then return 2 time units after the rising edge
  task automatic stepCycle();
    @(negedge clk);
    compareAll();
    @(posedge clk);
    #2;
  endtask

  task automatic waitResult(input string name, input int expLat, input logic [31:0] expRes);
    int lat;
    lat = 1;
    while (!outValid && lat < 10) begin
      stepCycle();
      lat++;
    end
    checkOutput({name, "_latency"}, 32'(lat), 32'(expLat));
    checkOutput({name, "_result"}, result, expRes);
  endtask

  task automatic applyStimulus(input string name, input logic [31:0] r1, input logic [31:0] r2,
                               input logic [1:0] b, input logic d,
                               input int expLat, input logic [31:0] expRes);
    int cnt;
    logic [31:0] rnd;
    cnt = 0;
    while (!inReady && cnt < 20) begin
      stepCycle();
      cnt++;
    end
    checkOutput({name, "_ready"}, 32'(inReady), 32'h1);
    inValid = 1'b1;
    inRs1   = r1;
    inRs2   = r2;
    inBs    = b;
    inDsmi  = d;
    stepCycle();
    inValid = 1'b0;
    rnd     = $urandom;
    inRs1   = $urandom;
    inRs2   = $urandom;
    inBs    = rnd[1:0];
    inDsmi  = rnd[2];
    waitResult(name, expLat, expRes);
  endtask

  initial begin
    logic [31:0] rnd;
    logic [31:0] held;
    int          validSeen;
    nChecks  = 0;
    nErrors  = 0;
    mInit    = 1'b0;
    mBusy    = 1'b0;
    mWait    = 0;
    mRes     = 32'h0;
    rst      = 1'b1;
    inValid  = 1'b0;
    inRs1    = 32'h0;
    inRs2    = 32'h0;
    inBs     = 2'd0;
    inDsmi   = 1'b0;
    outReady = 1'b1;

    buildTables();
    checkOutput("pin_mul_57_83", 32'(refMul(8'h57, 8'h83)), 32'hC1);
    checkOutput("pin_invs_63",   32'(invS[8'h63]), 32'h00);
    checkOutput("pin_invs_00",   32'(invS[8'h00]), 32'h52);
    checkOutput("pin_invs_7c",   32'(invS[8'h7C]), 32'h01);

    // Reset with a request and a ready pending: reset must win
    inValid = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    inValid = 1'b0;
    checkOutput("rst_in_ready",  32'(inReady),  32'h1);
    checkOutput("rst_busy",      32'(busy),     32'h0);
    checkOutput("rst_out_valid", 32'(outValid), 32'h0);
    checkOutput("rst_result",    result,        32'h0);
    rst = 1'b0;
    stepCycle();

    applyStimulus("s_63_bs0", 32'h0, 32'h00000063, 2'd0, 1'b0, 2, 32'h00000000);
    stepCycle();
    applyStimulus("s_00_bs3", 32'h0, 32'h00000000, 2'd3, 1'b0, 2, 32'h52000000);
    stepCycle();

    // Back-to-back: request held during DONE is taken only after the handshake
    applyStimulus("s_63_bs2", 32'h11111111, 32'h00630000, 2'd2, 1'b0, 2, 32'h11111111);
    inValid = 1'b1;
    inRs1   = 32'h0;
    inRs2   = 32'h0;
    inBs    = 2'd3;
    inDsmi  = 1'b0;
    stepCycle();
    checkOutput("b2b_idle_ready", 32'(inReady), 32'h1);
    stepCycle();
    inValid = 1'b0;
    checkOutput("b2b_busy", 32'(busy), 32'h1);
    waitResult("b2b", 2, 32'h52000000);
    stepCycle();

    if (DSMI_EN)
      applyStimulus("s_7c_mix", 32'h0, 32'h0000007C, 2'd0, 1'b1, 3, 32'h0B0D090E);
    else
      applyStimulus("s_7c_mix", 32'h0, 32'h0000007C, 2'd0, 1'b1, 2, 32'h00000001);
    stepCycle();
    applyStimulus("s_mix_bs1", 32'hA5A5_5A5A, 32'h1234_C356, 2'd1, 1'b1,
                  DSMI_EN ? 3 : 2, refResult(32'hA5A5_5A5A, 32'h1234_C356, 2'd1, 1'b1));
    stepCycle();

    // Consumer stalls for 5 cycles while new requests knock
    outReady = 1'b0;
    applyStimulus("stall", 32'hDEAD_BEEF, 32'h0000_6300, 2'd1, 1'b0, 2, 32'hDEAD_BEEF);
    held = result;
    for (int i = 0; i < 5; i++) begin
      rnd     = $urandom;
      inValid = 1'b1;
      inRs1   = $urandom;
      inRs2   = $urandom;
      inBs    = rnd[1:0];
      inDsmi  = rnd[2];
      stepCycle();
      checkOutput("stall_result",    result,         held);
      checkOutput("stall_out_valid", 32'(outValid),  32'h1);
      checkOutput("stall_in_ready",  32'(inReady),   32'h0);
    end
    inValid  = 1'b0;
    outReady = 1'b1;
    stepCycle();
    checkOutput("stall_release_ready", 32'(inReady),  32'h1);
    checkOutput("stall_release_valid", 32'(outValid), 32'h0);

    // Reset pulsed while in SUB discards the request
    inValid = 1'b1;
    inRs1   = 32'h0;
    inRs2   = 32'h0;
    inBs    = 2'd0;
    inDsmi  = 1'b0;
    stepCycle();
    inValid = 1'b0;
    rst     = 1'b1;
    stepCycle();
    rst = 1'b0;
    checkOutput("midrst_in_ready", 32'(inReady), 32'h1);
    checkOutput("midrst_busy",     32'(busy),    32'h0);
    validSeen = 0;
    for (int i = 0; i < 4; i++) begin
      if (outValid) validSeen++;
      stepCycle();
    end
    checkOutput("midrst_no_valid", 32'(validSeen), 32'h0);

    // Random traffic: random requests, consumer back-pressure and occasional resets
    for (int i = 0; i < 3000; i++) begin
      rnd      = $urandom;
      rst      = (rnd[7:2] == 6'd0);
      inValid  = rnd[8];
      outReady = (rnd[10:9] != 2'd0);
      inBs     = rnd[12:11];
      inDsmi   = rnd[13];
      inRs1    = $urandom;
      inRs2    = $urandom;
      stepCycle();
    end
    rst      = 1'b0;
    inValid  = 1'b0;
    outReady = 1'b1;
    repeat (6) stepCycle();

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
